label_sram_arb: RTL and testbench

Arbiter for the single-port 1024×8 label SRAM. It shares the SRAM between two requesters:
- **m0:** the component-labeling engine, which is the high-priority streaming master.
- **m1:** the host/readback port, which reads final labels and patches the table.

The block grants at most one SRAM access per cycle and routes each read return to the requester that issued it. A starvation guard ensures m1 progresses while m0 is streaming continuously.

---
 rtl/label_sram_pkg.sv | 12 +
 rtl/label_sram_arb_if.sv | 16 +
 rtl/label_sram_prio.sv | 32 +++
 rtl/label_sram_arb.sv | 78 +++++++
 tb/tb_label_sram_arb.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/label_sram_pkg.sv
// Shared types and defaults for the label SRAM arbiter.
package label_sram_pkg;
  localparam int DEF_AW   = 10;
  localparam int DEF_DW   = 8;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;
endpackage

// File: rtl/label_sram_arb_if.sv
// One requester port of the label SRAM arbiter (request + read return).
interface label_sram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/label_sram_prio.sv
// Fixed-priority grant (m0 high) with a starvation override for m1,
// plus the next value of the m1 starvation counter.
module label_sram_prio
  import label_sram_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                req0,
  input  logic                req1,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                gnt0,
  output logic                gnt1,
  output logic [STARVE_W-1:0] starve_nxt
);
  localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

  logic force1;

  // m1 wins when it has waited SMAX cycles, otherwise m0 has priority.
  always_comb begin
    force1 = req1 && (starve_cnt == SMAX);
    gnt1   = force1 || (req1 && !req0);
    gnt0   = req0 && !force1;
  end

  // Count consecutive denied m1 cycles; any grant or idle cycle restarts it.
  always_comb begin
    starve_nxt = '0;
    if (req1 && !gnt1)
      starve_nxt = (starve_cnt >= SMAX) ? SMAX : starve_cnt + 1'b1;
  end
endmodule

// File: rtl/label_sram_arb.sv
// Two-requester arbiter for the single-port 1024x8 label SRAM.
// One access per cycle; read data returns one cycle after the grant and
// is steered to the requester recorded in rd_own.
module label_sram_arb
  import label_sram_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  label_sram_arb_if.slave  m0,
  label_sram_arb_if.slave  m1,
  output logic [AW-1:0]    sram_a,
  output logic [DW-1:0]    sram_d,
  output logic             sram_wen,
  input  logic [DW-1:0]    sram_q,
  output logic             busy
);
  logic                req0, req1, gnt0, gnt1;
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  owner_t              rd_own, rd_own_nxt;

  // Requests are masked while reset is asserted so no grant or SRAM
  // strobe can leak out during reset.
  assign req0 = m0.req & reset;
  assign req1 = m1.req & reset;

  label_sram_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .req0       (req0),
    .req1       (req1),
    .starve_cnt (starve_cnt),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .starve_nxt (starve_nxt)
  );

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // SRAM port mux: granted requester drives, idle bus parks at 0 / wen high.
  always_comb begin
    sram_a     = '0;
    sram_d     = '0;
    sram_wen   = 1'b1;
    rd_own_nxt = OWN_NONE;
    if (gnt0) begin
      sram_a   = m0.addr;
      sram_d   = m0.wdata;
      sram_wen = ~m0.we;
      if (!m0.we) rd_own_nxt = OWN_M0;
    end else if (gnt1) begin
      sram_a   = m1.addr;
      sram_d   = m1.wdata;
      sram_wen = ~m1.we;
      if (!m1.we) rd_own_nxt = OWN_M1;
    end
  end

  // Starvation counter and read-return owner; reset drops any pending return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      rd_own     <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      rd_own     <= rd_own_nxt;
    end
  end

  assign m0.rvalid = (rd_own == OWN_M0);
  assign m1.rvalid = (rd_own == OWN_M1);
  assign m0.rdata  = m0.rvalid ? sram_q : '0;
  assign m1.rdata  = m1.rvalid ? sram_q : '0;

  assign busy = (rd_own != OWN_NONE) | req0 | req1;
endmodule

// File: tb/tb_label_sram_arb.sv
// Directed bench for label_sram_arb with a behavioural 1024x8 SRAM.
module tb_label_sram_arb;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] sram_a;
  logic [7:0] sram_d, sram_q;
  logic       sram_wen, busy;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mem [1024];

  label_sram_arb_if #(.AW(10), .DW(8)) m0_if ();
  label_sram_arb_if #(.AW(10), .DW(8)) m1_if ();

  label_sram_arb #(.AW(10), .DW(8), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0       (m0_if.slave),
    .m1       (m1_if.slave),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_wen (sram_wen),
    .sram_q   (sram_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (!sram_wen) mem[sram_a] <= sram_d;
    sram_q <= mem[sram_a];
  end

  // Drive one cycle of requests at the falling edge, then settle before sampling.
  task automatic drv(input logic r0, input logic w0, input logic [9:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic [9:0] a1, input logic [7:0] d1);
    @(negedge clk);
    m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    #2;
  endtask

  task automatic idle();
    drv(0, 0, 10'h0, 8'h0, 0, 0, 10'h0, 8'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1'($urandom), 1'($urandom), 10'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), 10'($urandom), 8'($urandom));
      checks++;
      if (sram_wen !== 1'b1 || m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 ||
          m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 || busy !== 1'b0 ||
          sram_a !== 10'h0 || sram_d !== 8'h0) begin
        failures++;
        $display("FAIL reset_hold: wen=%b g0=%b g1=%b rv0=%b rv1=%b busy=%b a=%h d=%h want wen=1 rest 0",
                 sram_wen, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, busy, sram_a, sram_d);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (sram_wen !== 1'b1 || m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 ||
          m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 || busy !== 1'b0 ||
          m0_if.rdata !== 8'h0 || m1_if.rdata !== 8'h0) begin
        failures++;
        $display("FAIL reset_release: wen=%b g0=%b g1=%b rv0=%b rv1=%b busy=%b want wen=1 rest 0",
                 sram_wen, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, busy);
      end
    end
  endtask

  task automatic test_m0_write_read();
    drv(1, 1, 10'h1F3, 8'h2A, 0, 0, 10'h0, 8'h0);
    checks++;
    if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0 || sram_wen !== 1'b0 ||
        sram_a !== 10'h1F3 || sram_d !== 8'h2A || busy !== 1'b1) begin
      failures++;
      $display("FAIL m0_write: g0=%b g1=%b wen=%b a=%h d=%h busy=%b want 1 0 0 1f3 2a 1",
               m0_if.gnt, m1_if.gnt, sram_wen, sram_a, sram_d, busy);
    end
    drv(1, 0, 10'h1F3, 8'h00, 0, 0, 10'h0, 8'h0);
    checks++;
    if (m0_if.gnt !== 1'b1 || sram_wen !== 1'b1 || sram_a !== 10'h1F3 ||
        m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL m0_read_issue: g0=%b wen=%b a=%h rv0=%b rv1=%b want 1 1 1f3 0 0",
               m0_if.gnt, sram_wen, sram_a, m0_if.rvalid, m1_if.rvalid);
    end
    idle();
    checks++;
    if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 8'h2A || m1_if.rvalid !== 1'b0 ||
        m1_if.rdata !== 8'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL m0_read_return: rv0=%b rd0=%h rv1=%b rd1=%h busy=%b want 1 2a 0 00 1",
               m0_if.rvalid, m0_if.rdata, m1_if.rvalid, m1_if.rdata, busy);
    end
    idle();
    checks++;
    if (m0_if.rvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL m0_read_single: rv0=%b busy=%b want 0 0", m0_if.rvalid, busy);
    end
  endtask

  // Expected grant sequence with STARVE_MAX=4: m0 m0 m0 m0 m1, repeating.
  task automatic test_contention();
    int run = 0;
    for (int i = 0; i < 15; i++) begin
      logic exp1, prev1;
      exp1  = (i % 5) == 4;
      prev1 = (i > 0) && (((i - 1) % 5) == 4);
      drv(1, 0, 10'h000, 8'h0, 1, 0, 10'h1F3, 8'h0);
      checks++;
      if (m1_if.gnt !== exp1 || m0_if.gnt !== !exp1) begin
        failures++;
        $display("FAIL contention_gnt[%0d]: g0=%b g1=%b want %b %b", i, m0_if.gnt, m1_if.gnt, !exp1, exp1);
      end
      if (i > 0) begin
        checks++;
        if (m1_if.rvalid !== prev1 || m0_if.rvalid !== !prev1 ||
            (prev1 && m1_if.rdata !== 8'h2A)) begin
          failures++;
          $display("FAIL contention_ret[%0d]: rv0=%b rv1=%b rd1=%h want %b %b 2a",
                   i, m0_if.rvalid, m1_if.rvalid, m1_if.rdata, !prev1, prev1);
        end
      end
      run = (m1_if.gnt === 1'b1) ? 0 : run + 1;
      checks++;
      if (run > 4) begin
        failures++;
        $display("FAIL contention_starve[%0d]: denied run=%0d want <=4", i, run);
      end
    end
  endtask

  task automatic test_interleaved();
    drv(1, 1, 10'h000, 8'h11, 0, 0, 10'h0, 8'h0);
    drv(1, 1, 10'h3FF, 8'h22, 0, 0, 10'h0, 8'h0);
    drv(1, 0, 10'h000, 8'h00, 0, 0, 10'h0, 8'h0);
    checks++;
    if (m0_if.gnt !== 1'b1 || sram_a !== 10'h000 || sram_wen !== 1'b1) begin
      failures++;
      $display("FAIL inter_m0_issue: g0=%b a=%h wen=%b want 1 000 1", m0_if.gnt, sram_a, sram_wen);
    end
    drv(0, 0, 10'h000, 8'h00, 1, 0, 10'h3FF, 8'h00);
    checks++;
    if (m1_if.gnt !== 1'b1 || m0_if.gnt !== 1'b0 || sram_a !== 10'h3FF ||
        m0_if.rvalid !== 1'b1 || m0_if.rdata !== 8'h11 || m1_if.rvalid !== 1'b0 || m1_if.rdata !== 8'h0) begin
      failures++;
      $display("FAIL inter_n1: g1=%b g0=%b a=%h rv0=%b rd0=%h rv1=%b rd1=%h want 1 0 3ff 1 11 0 00",
               m1_if.gnt, m0_if.gnt, sram_a, m0_if.rvalid, m0_if.rdata, m1_if.rvalid, m1_if.rdata);
    end
    idle();
    checks++;
    if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== 8'h22 || m0_if.rvalid !== 1'b0 || m0_if.rdata !== 8'h0) begin
      failures++;
      $display("FAIL inter_n2: rv1=%b rd1=%h rv0=%b rd0=%h want 1 22 0 00",
               m1_if.rvalid, m1_if.rdata, m0_if.rvalid, m0_if.rdata);
    end
  endtask

  task automatic test_counter_clear();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 10'h000, 8'h0, 1, 0, 10'h3FF, 8'h0);
      checks++;
      if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0) begin
        failures++;
        $display("FAIL clr_pre[%0d]: g0=%b g1=%b want 1 0", i, m0_if.gnt, m1_if.gnt);
      end
    end
    drv(1, 0, 10'h000, 8'h0, 0, 0, 10'h3FF, 8'h0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 10'h000, 8'h0, 1, 0, 10'h3FF, 8'h0);
      checks++;
      if (m1_if.gnt !== (i == 4) || m0_if.gnt !== (i != 4)) begin
        failures++;
        $display("FAIL clr_post[%0d]: g0=%b g1=%b want %b %b", i, m0_if.gnt, m1_if.gnt, i != 4, i == 4);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    drv(0, 0, 10'h000, 8'h0, 1, 0, 10'h3FF, 8'h0);
    checks++;
    if (m1_if.gnt !== 1'b1 || sram_wen !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_issue: g1=%b wen=%b want 1 1", m1_if.gnt, sram_wen);
    end
    m1_if.req = 1'b0;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (m1_if.rvalid !== 1'b0 || m0_if.rvalid !== 1'b0 || busy !== 1'b0 || dut.starve_cnt !== 4'd0) begin
        failures++;
        $display("FAIL rst_mid_ret[%0d]: rv1=%b rv0=%b busy=%b cnt=%0d want 0 0 0 0",
                 i, m1_if.rvalid, m0_if.rvalid, busy, dut.starve_cnt);
      end
    end
    // Reset in a cycle where m1 is denied: the count must not survive.
    drv(1, 0, 10'h000, 8'h0, 1, 0, 10'h3FF, 8'h0);
    drv(1, 0, 10'h000, 8'h0, 1, 0, 10'h3FF, 8'h0);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    idle();
    checks++;
    if (dut.starve_cnt !== 4'd0 || m0_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_cnt: cnt=%0d rv0=%b want 0 0", dut.starve_cnt, m0_if.rvalid);
    end
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 10'h000, 8'h0, 1, 0, 10'h3FF, 8'h0);
      checks++;
      if (m1_if.gnt !== (i == 4)) begin
        failures++;
        $display("FAIL rst_mid_starve[%0d]: g1=%b want %b", i, m1_if.gnt, i == 4);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
    test_reset();
    test_m0_write_read();
    test_contention();
    test_interleaved();
    test_counter_clear();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
